// File: rtl/m_instrtimer_if.sv
// Bus bundle for m_instrtimer: start/boundary controls and address in, ALU-B operand and counters out.
interface m_instrtimer_if;
    logic        start;
    logic        sa16;
    logic        sa17;
    logic [31:0] ADR_O;
    logic [31:0] QQ;
    logic        corerunning;
    logic        nobuserror;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    modport master (
        output start, sa16, sa17, ADR_O,
        input  QQ, corerunning, nobuserror, mcycle, minstret
    );

    modport slave (
        input  start, sa16, sa17, ADR_O,
        output QQ, corerunning, nobuserror, mcycle, minstret
    );
endinterface

// File: rtl/m_instrtimer.sv
// Per-instruction timer folded into a 64-bit mcycle at boundaries, start qualification, timeout bus error, ALU-B mux.
// Latency: QQ/nobuserror combinational; mcycle/minstret/corerunning visible the cycle after the sampling edge.
// Backpressure: none, always accepts; INSTRTIMER_MINSTRET_EN adds the retired-instruction counter.
module m_instrtimer #(
    parameter int CNTW     = 6,
    parameter int TIMEOUT  = 63,
    parameter int STARTLEN = 64
) (
    input  logic           clk,
    input  logic           rst,
    m_instrtimer_if.slave  bus
);
    localparam logic [CNTW-1:0] TMO   = CNTW'(TIMEOUT);
    localparam logic [CNTW-1:0] ONE   = CNTW'(1);
    localparam logic [15:0]     QLAST = 16'(STARTLEN - 1);

    logic [15:0]     qcnt;
    logic [CNTW-1:0] rccnt;
    logic            running;
    logic            tflag;
    logic [63:0]     mcycle_q;
    logic            hit;
    logic [31:0]     qq;

    // Boundary in the same cycle suppresses the error; tflag limits it to one cycle.
    assign hit = running & ~bus.sa16 & (rccnt == TMO) & ~tflag;

    always_ff @(posedge clk) begin
        if (rst) begin
            qcnt     <= '0;
            rccnt    <= ONE;
            running  <= 1'b0;
            tflag    <= 1'b0;
            mcycle_q <= '0;
        end else if (!running) begin
            rccnt <= ONE;
            tflag <= 1'b0;
            if (bus.start) begin
                qcnt <= qcnt + 16'd1;
                if (qcnt == QLAST)
                    running <= 1'b1;
            end else begin
                qcnt <= '0;
            end
        end else if (bus.sa16) begin
            mcycle_q <= mcycle_q + 64'(rccnt);
            rccnt    <= ONE;
            tflag    <= 1'b0;
        end else begin
            if (rccnt != TMO)
                rccnt <= rccnt + ONE;
            if (hit)
                tflag <= 1'b1;
        end
    end

`ifdef INSTRTIMER_MINSTRET_EN
    logic [63:0] minstret_q;

    always_ff @(posedge clk) begin
        if (rst)
            minstret_q <= '0;
        else if (running && bus.sa16)
            minstret_q <= minstret_q + 64'd1;
    end

    assign bus.minstret = minstret_q;
`else
    assign bus.minstret = 64'h0;
`endif

    // Boundary exposes the timer in the low bits; otherwise the +3/+4 increment pattern.
    always_comb begin
        qq = bus.ADR_O;
        if (bus.sa16)
            qq[CNTW-1:0] = rccnt;
        else if (!bus.sa17)
            qq[1:0] = 2'b11;
    end

    assign bus.QQ          = qq;
    assign bus.corerunning = running;
    assign bus.nobuserror  = ~hit;
    assign bus.mcycle      = mcycle_q;
endmodule

// File: doc/m_instrtimer.md
Name: m_instrtimer

Overview:
Parametrised successor to the per-instruction cycle counter. It times each instruction with a CNTW-bit timer and folds the timer value into an internal 64-bit cycle accumulator at every instruction boundary. It raises a bus-error indication on instruction timeout and qualifies core start-up. It also multiplexes the timer with ADR_O onto ALU input B (QQ), and supplies the +3/+4 PC-increment pattern.

Parameters:
CNTW, 6, instruction-timer width; legal range 4..16.
TIMEOUT, 63, timer value that flags a bus error; 2 <= TIMEOUT <= 2^CNTW-1.
STARTLEN, 64, consecutive start-high cycles required before corerunning; legal range 1..65535.

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  synchronous reset, active high.
start  input  1  start request / enable; must stay high STARTLEN consecutive cycles.
sa16  input  1  instruction boundary; selects timer onto QQ.
sa17  input  1  with sa16=0: 1 passes ADR_O, 0 forces QQ[1:0]=2'b11.
ADR_O  input  32  current address, ALU-B source.
QQ  output  32  ALU input B.
corerunning  output  1  core released; sticky until rst.
nobuserror  output  1  low for exactly the timeout cycle.
mcycle  output  64  accumulated cycle count (registered).
minstret  output  64  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (rst=1 at edge), values visible the following cycle:
  - rccnt=1, qualification count=0, corerunning=0.
  - mcycle=0, minstret=0.
  - timeout flag=0, so nobuserror=1.
- Reset mid-operation: every register returns to its reset value. No partial accumulation is retained.
- Start qualification, while corerunning=0:
  - qcnt increments on each cycle with start=1 and clears to 0 on any cycle with start=0.
  - corerunning goes 1 on the edge that samples the STARTLEN-th consecutive start=1.
  - STARTLEN=1: corerunning rises one cycle after start is first seen high.
  - Once corerunning=1, start is ignored and qcnt is don't-care.
- Instruction timer, rccnt (CNTW bits):
  - While corerunning=0: held at 1.
  - While running with sa16=0: increments by 1 per cycle and saturates at TIMEOUT (never wraps).
  - While running with sa16=1: mcycle <= mcycle + zero-extend(rccnt), then rccnt <= 1.
  - The 64-bit add wraps modulo 2^64.
- Resulting mcycle property: for any sequence of boundaries with no timeout, mcycle equals the number of running cycles elapsed, measured up to the cycle before the last boundary edge.
- Timeout:
  - nobuserror = ~(corerunning & ~sa16 & rccnt==TIMEOUT & ~tflag), purely combinational from registers and sa16.
  - tflag sets on the edge after the first such cycle and clears on sa16, so nobuserror is low for exactly one cycle per timeout.
  - sa16=1 in the same cycle that rccnt==TIMEOUT: boundary wins, no error.
  - While saturated, mcycle undercounts; this is accepted, because the trap handler restarts execution.
- QQ mux:
  - sa16=1: QQ[CNTW-1:0]=rccnt; QQ[31:CNTW]=ADR_O[31:CNTW].
  - sa16=0, sa17=1: QQ=ADR_O.
  - sa16=0, sa17=0: QQ=ADR_O | 32'h3.
  - Combinational, no latency.
- mcycle and minstret outputs are registers; updates are visible the cycle after the boundary.

Optional Feature:
Macro INSTRTIMER_MINSTRET_EN.
- Defined: 64-bit minstret register increments by 1 (wrapping) on every sa16=1 cycle while corerunning=1, and resets to 0.
- Undefined: minstret is tied to 64'h0 and no register is inferred. All other behaviour is identical.

Test Plan:
1. Start-up: rst 2 cycles, then start=1 for 63 cycles, start=0 for 1 cycle, then start=1 for 64 cycles -> corerunning=0 throughout the first 63; it rises exactly after the 64th consecutive high (default params).
2. Accumulation: running, sa16 pulses 5 cycles apart, three times -> rccnt=5 on QQ[5:0] at each pulse; mcycle reads 5, 10, 15 the cycle after each pulse; minstret 1, 2, 3 (macro defined).
3. Timeout: running, no sa16 -> rccnt reaches 63; nobuserror=0 for exactly one cycle; rccnt stays at 63; a later sa16 clears it; no second error before the next 63 cycles.
4. Boundary race: sa16=1 in the cycle rccnt==63 -> nobuserror stays 1; mcycle increases by 63.
5. QQ mux: ADR_O=32'h1234_5678 -> QQ=32'h1234_5678 for sa16=0/sa17=1, QQ=32'h1234_567B for sa16=0/sa17=0, QQ=32'h1234_5640|rccnt for sa16=1.
6. Mid-operation reset plus wrap: preload mcycle to 2^64-3 and add 5 -> mcycle=2. Then assert rst -> corerunning=0, mcycle=0, nobuserror=1 the next cycle. Rebuild with CNTW=8, TIMEOUT=200 and verify the error fires at 200.
